decimal_parser: RTL
===================

Name: decimal_parser

Overview:
Receives an ASCII decimal number one byte at a time from the UART receive path and accumulates it into a binary value. This is the inverse of the binary-to-decimal digit converter that feeds the seven-segment display. A terminator byte commits the result as a one-cycle strobe. Malformed or overflowing input is discarded up to the next terminator and then reported as an error. The committed value drives the display/TX controller, e.g. "12345\r" produces 16'd12345.

Parameters:
DATA_W, 16, width of accumulated binary value
MAX_DIGITS, 5, maximum digit characters per number, leading zeros included
TERM_CHAR, 8'h0D, terminator byte (CR)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state and outputs
rx_data  in  8  received byte; valid only while rx_valid=1
rx_valid  in  1  one-cycle strobe per received byte; no backpressure
value  out  DATA_W  last committed number; held between commits
value_valid  out  1  one-cycle pulse when value updates
err_ovf  out  1  one-cycle pulse: discarded number exceeded 2^DATA_W-1 or MAX_DIGITS
err_char  out  1  one-cycle pulse: discarded number contained an illegal byte
digit_cnt  out  3  digits accepted in the current number (0..MAX_DIGITS)
busy  out  1  high in ACCUM or SKIP

Behaviour:
- Reset values: value=0, value_valid=0, err_ovf=0, err_char=0, digit_cnt=0, busy=0, acc=0, state=IDLE, sticky error flags cleared.
- Byte classes: DIGIT is 8'h30..8'h39 (d = rx_data-8'h30). TERM is TERM_CHAR. OTHER is any other byte.
- Bytes are sampled only on cycles where rx_valid=1. A rising edge with rx_valid=0 changes no state.
- IDLE:
  - DIGIT -> acc=d, digit_cnt=1, go to ACCUM.
  - TERM -> ignored (empty line); no pulse.
  - OTHER -> set char flag, go to SKIP.
- ACCUM:
  - DIGIT:
    - Compute nxt = acc*10 + d in DATA_W+4 bits, as (acc<<3)+(acc<<1)+d.
    - If digit_cnt==MAX_DIGITS or nxt > 2^DATA_W-1: set ovf flag, go to SKIP; acc unchanged.
    - Otherwise acc=nxt and digit_cnt+1.
  - TERM -> value=acc, value_valid=1 for the next cycle only; clear acc and digit_cnt; go to IDLE.
  - OTHER -> set char flag, go to SKIP.
- SKIP:
  - DIGIT and OTHER bytes are consumed silently; the flags are sticky.
  - OTHER additionally sets the char flag.
  - TERM -> pulse err_ovf and/or err_char per the sticky flags (both may pulse together); clear the flags, acc and digit_cnt; go to IDLE. value is unchanged.
- Latency: value_valid, err_ovf and err_char are registered. They are high exactly in the cycle after the clock edge that sampled TERM.
- Back-to-back bytes (rx_valid high on consecutive cycles) are fully supported; a new number may begin in the cycle its predecessor's value_valid is high.
- value_valid and the error pulses are mutually exclusive.
- Reset asserted mid-number aborts it. No pulse is emitted, and value returns to 0.
- Leading zeros are accepted and count toward MAX_DIGITS: "00045" gives 45; "000045" overflows on the sixth digit.

Decomposition:
- Package decimal_pkg holds:
  - state enum {IDLE, ACCUM, SKIP}
  - ASCII_ZERO=8'h30, ASCII_NINE=8'h39, ASCII_CR=8'h0D
  - function is_digit(byte)
- One combinational sub-module, mul10_add (acc, d -> nxt, DATA_W+4 bits), isolates the arithmetic for separate unit test.
- The FSM, accumulator and output registers live in decimal_parser.

Test Plan:
- Send "12345\r" with one idle cycle between bytes -> one value_valid pulse with value=16'd12345; no error pulses; digit_cnt returns to 0.
- Send "05123\r" then "00045\r" back-to-back with rx_valid continuous -> value=5123, then 45; two value_valid pulses, each 1 cycle wide.
- Boundary values:
  - Send "65535\r" -> value=65535.
  - Send "65536\r" -> err_ovf pulse only; value stays 65535.
  - Send "123456\r" -> err_ovf pulse.
- Send "12a4\r" -> err_char pulse; value unchanged. Send "\r" alone -> no pulse of any kind.
- Send "9999" then assert reset for 2 cycles, then send "7\r" -> value=0 during reset with no pulses; after the sequence value=7 with a single value_valid.
- Send "99999x\r" -> err_ovf and err_char pulse in the same cycle; busy high from the first byte until the TERM edge.

Source files
------------

// File: rtl/decimal_pkg.sv
// Shared types and constants for the ASCII decimal parser.
// Byte classification helpers live here so the bench and units agree on them.
package decimal_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      SKIP  = 2'd2
   } state_t;

   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_NINE = 8'h39;
   localparam logic [7:0] ASCII_CR   = 8'h0D;

   function automatic logic is_digit(input logic [7:0] b);
      return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
   endfunction

endpackage

// File: rtl/decimal_parser_mul10_add.sv
// Combinational acc*10 + d, widened by four bits so overflow is visible.
// Shift-add form keeps the datapath free of a generic multiplier.
module mul10_add #(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] acc,
   input  logic [3:0]        d,
   output logic [DATA_W+3:0] nxt
);

   logic [DATA_W+3:0] acc_wide_s;

   // Compute 8*acc + 2*acc + d in the widened domain
   always_comb begin
      acc_wide_s = {4'd0, acc};
      nxt        = (acc_wide_s << 3) + (acc_wide_s << 1) + {{DATA_W{1'b0}}, d};
   end

endmodule

// File: rtl/decimal_parser.sv
// Accumulates an ASCII decimal number byte by byte and commits it on a
// terminator; malformed or oversized numbers are skipped and reported.
module decimal_parser
   import decimal_pkg::*;
#(
   parameter int          DATA_W     = 16,
   parameter int          MAX_DIGITS = 5,
   parameter logic [7:0]  TERM_CHAR  = ASCII_CR
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [DATA_W-1:0] value,
   output logic              value_valid,
   output logic              err_ovf,
   output logic              err_char,
   output logic [2:0]        digit_cnt,
   output logic              busy
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              ovf_flag_q, ovf_flag_d;
   logic              chr_flag_q, chr_flag_d;
   logic [DATA_W-1:0] value_q, value_d;
   logic              value_valid_q, value_valid_d;
   logic              err_ovf_q, err_ovf_d;
   logic              err_char_q, err_char_d;
   logic              busy_q, busy_d;

   logic              is_term_s;
   logic              is_digit_s;
   logic [3:0]        digit_s;
   logic [DATA_W+3:0] nxt_s;
   logic              too_big_s;
   logic              cnt_full_s;

   // The low nibble of '0'..'9' is the digit value itself
   assign digit_s    = rx_data[3:0];
   assign is_term_s  = (rx_data == TERM_CHAR);
   assign is_digit_s = is_digit(rx_data) && !is_term_s;
   assign too_big_s  = (nxt_s[DATA_W+3:DATA_W] != 4'd0);
   assign cnt_full_s = (cnt_q == 3'(MAX_DIGITS));

   mul10_add #(.DATA_W(DATA_W)) u_mul10_add (
      .acc (acc_q),
      .d   (digit_s),
      .nxt (nxt_s)
   );

   // Next-state, accumulator and output pulse logic
   always_comb begin
      state_d       = state_q;
      acc_d         = acc_q;
      cnt_d         = cnt_q;
      ovf_flag_d    = ovf_flag_q;
      chr_flag_d    = chr_flag_q;
      value_d       = value_q;
      value_valid_d = 1'b0;
      err_ovf_d     = 1'b0;
      err_char_d    = 1'b0;

      if (rx_valid) begin
         case (state_q)
            IDLE: begin
               if (is_term_s) begin
                  state_d = IDLE;
               end else if (is_digit_s) begin
                  acc_d   = {{(DATA_W-4){1'b0}}, digit_s};
                  cnt_d   = 3'd1;
                  state_d = ACCUM;
               end else begin
                  chr_flag_d = 1'b1;
                  state_d    = SKIP;
               end
            end
            ACCUM: begin
               if (is_term_s) begin
                  value_d       = acc_q;
                  value_valid_d = 1'b1;
                  acc_d         = {DATA_W{1'b0}};
                  cnt_d         = 3'd0;
                  state_d       = IDLE;
               end else if (is_digit_s) begin
                  if (cnt_full_s || too_big_s) begin
                     ovf_flag_d = 1'b1;
                     state_d    = SKIP;
                  end else begin
                     acc_d = nxt_s[DATA_W-1:0];
                     cnt_d = cnt_q + 3'd1;
                  end
               end else begin
                  chr_flag_d = 1'b1;
                  state_d    = SKIP;
               end
            end
            SKIP: begin
               if (is_term_s) begin
                  err_ovf_d  = ovf_flag_q;
                  err_char_d = chr_flag_q;
                  ovf_flag_d = 1'b0;
                  chr_flag_d = 1'b0;
                  acc_d      = {DATA_W{1'b0}};
                  cnt_d      = 3'd0;
                  state_d    = IDLE;
               end else if (is_digit_s) begin
                  state_d = SKIP;
               end else begin
                  chr_flag_d = 1'b1;
                  state_d    = SKIP;
               end
            end
            default: begin
               ovf_flag_d = 1'b0;
               chr_flag_d = 1'b0;
               acc_d      = {DATA_W{1'b0}};
               cnt_d      = 3'd0;
               state_d    = IDLE;
            end
         endcase
      end else begin
         state_d = state_q;
      end

      busy_d = (state_d != IDLE);
   end

   // State, accumulator and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         acc_q         <= {DATA_W{1'b0}};
         cnt_q         <= 3'd0;
         ovf_flag_q    <= 1'b0;
         chr_flag_q    <= 1'b0;
         value_q       <= {DATA_W{1'b0}};
         value_valid_q <= 1'b0;
         err_ovf_q     <= 1'b0;
         err_char_q    <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         acc_q         <= acc_d;
         cnt_q         <= cnt_d;
         ovf_flag_q    <= ovf_flag_d;
         chr_flag_q    <= chr_flag_d;
         value_q       <= value_d;
         value_valid_q <= value_valid_d;
         err_ovf_q     <= err_ovf_d;
         err_char_q    <= err_char_d;
         busy_q        <= busy_d;
      end
   end

   assign value       = value_q;
   assign value_valid = value_valid_q;
   assign err_ovf     = err_ovf_q;
   assign err_char    = err_char_q;
   assign digit_cnt   = cnt_q;
   assign busy        = busy_q;

endmodule
